ppu_mem_arbiter: RTL and testbench
==================================

# ppu_mem_arbiter

Arbitrates the shared VRAM (0x8000–0x9FFF) and OAM (0xFE00–0xFE9F) arrays between the CPU bus, the PPU fetch port and an OAM DMA engine. Sits between the PPU, the CPU memory map and the two synchronous RAMs. Enforces mode-based CPU lockout: VRAM is blocked in DRAW, OAM is blocked in SCAN and DRAW. Owns the FF46 DMA trigger and copies 160 bytes into OAM.

## Interface
Parameters:
- DMA_LEN, 160: bytes per OAM DMA transfer.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- LCD_EN  in  1  LCDC[7]; when 0, mode lockout is disabled.
- PPU_MODE  in  2  0=H_BLANK, 1=V_BLANK, 2=SCAN, 3=DRAW.
- CPU_ADDR  in  16  CPU address.
- CPU_RD / CPU_WR  in  1  CPU strobes.
- CPU_DATA_out  in  8  CPU write data.
- CPU_DATA_in  out  8  read data returned to the CPU. Valid the cycle after CPU_RD.
- PPU_RD  in  1  PPU read strobe.
- PPU_ADDR  in  16  PPU address (VRAM or OAM).
- PPU_DATA_in  out  8  read data returned to the PPU. Valid the cycle after PPU_RD.
- VRAM_ADDR  out  13  VRAM address.
- VRAM_WR  out  1  VRAM write strobe.
- VRAM_WDATA  out  8  VRAM write data.
- VRAM_RDATA  in  8  VRAM read data, 1-cycle read latency.
- OAM_ADDR  out  8  OAM address.
- OAM_WR  out  1  OAM write strobe.
- OAM_WDATA  out  8  OAM write data.
- OAM_RDATA  in  8  OAM read data, 1-cycle read latency.
- DMA_ADDR  out  16  DMA source address on the system bus.
- DMA_RD  out  1  DMA source read strobe.
- DMA_DATA_in  in  8  DMA source data, valid the cycle after DMA_RD.
- DMA_ACTIVE  out  1  high while a transfer is in progress.

## Operation
Region decode:
- VRAM hit: ADDR[15:13]==3'b100.
- OAM hit: ADDR in FE00–FE9F.
- FEA0–FEFF is unusable. CPU reads there return 8'hFF; CPU writes there are dropped.

Lock rules (apply only when LCD_EN=1):
- vram_locked = (mode==DRAW).
- oam_locked = (mode==SCAN || mode==DRAW || DMA_ACTIVE).
- DMA_ACTIVE locks OAM from the CPU regardless of LCD_EN.

Port priority:
- VRAM: PPU when vram_locked; otherwise CPU, with the PPU served only if the CPU is not accessing VRAM that cycle.
- OAM: DMA > PPU (when oam_locked by mode) > CPU.

Rejected accesses:
- A losing or locked CPU read returns 8'hFF.
- A losing or locked CPU write is dropped; no RAM strobe is issued.
- A losing PPU read returns 8'hFF.

Read return path:
- A 2-bit source select (NONE/VRAM/OAM/FF) is registered with each granted read.
- Next cycle, the data output muxes RAM data by that select.
- The select is tracked independently for the CPU and PPU paths.

DMA state machine (sub-module):
- IDLE → on CPU write to FF46 with value V, latch src_hi = (V>=8'hE0) ? V-8'h20 : V, clear idx, go to START.
- START (1 cycle) → READ.
- READ: DMA_RD=1, DMA_ADDR={src_hi, idx} → WRITE.
- WRITE: OAM_WR=1, OAM_ADDR=idx, OAM_WDATA=DMA_DATA_in. If idx==DMA_LEN-1 go to IDLE; otherwise idx+1 and go to READ.
- DMA_ACTIVE is high in START, READ and WRITE.
- A write to FF46 while active restarts the transfer at START with the new source; the in-flight byte is discarded.
- FF46 reads are not decoded here; the register lives in the PPU register file.

## Timing
- Address and strobe routing to the RAMs is combinational from inputs and the current grant.
- Read data reaches the requester 1 cycle after the strobe.
- A DMA transfer takes 1 + 2·DMA_LEN = 321 cycles from the FF46 write-accept edge to DMA_ACTIVE falling.
- Reset values:
  - DMA state IDLE, idx 0, DMA_ACTIVE 0, DMA_RD 0.
  - VRAM_WR 0, OAM_WR 0.
  - Both read selects NONE, so CPU_DATA_in and PPU_DATA_in read 8'hFF.
  - All address outputs 0.
- Reset mid-DMA: abort at the reset edge. No further OAM writes. Bytes already copied remain.
- Mode change from SCAN to H_BLANK on the same edge as a CPU OAM read: the lock is evaluated on the current PPU_MODE, so the read is granted.
- Simultaneous CPU and PPU VRAM read in H_BLANK: the CPU is granted and the PPU gets 8'hFF.

## Configuration
- PPU_ARB_DMA_EN defined: the DMA sub-module is instantiated and behaves as above.
- PPU_ARB_DMA_EN undefined: writes to FF46 are ignored. DMA_ACTIVE, DMA_RD and DMA_ADDR are tied to 0. OAM arbitration reduces to PPU > CPU.

## Structure
- Shared package ppu_pkg holds:
  - PPU_STATES_t (H_BLANK, V_BLANK, SCAN, DRAW);
  - the constants OAM_BASE_ADDR, OAM_END_ADDR, VRAM_BASE_ADDR, DMA_REG_ADDR=16'hFF46;
  - the read-select enum.
- One sub-module: ppu_oam_dma, containing the DMA FSM, idx counter and source latch.
- Arbitration and return muxing live in the top module.

## Test plan
- LCD_EN=1, mode=DRAW, CPU_RD at 0x8010 → CPU_DATA_in=8'hFF next cycle and VRAM_ADDR follows PPU_ADDR. Then mode=H_BLANK, with VRAM[0x10]=8'h5A → CPU_DATA_in=8'h5A.
- mode=SCAN, CPU_WR 0xFE04=8'h33 → no OAM_WR. Repeat in V_BLANK → OAM_WR with OAM_ADDR=8'h04, OAM_WDATA=8'h33.
- CPU writes FF46=8'hC1 → DMA_ACTIVE rises. Byte k is read from 0xC100+k and written to OAM[k]. DMA_ACTIVE falls exactly 321 cycles later. During the transfer, CPU reads of 0xFE00 return 8'hFF.
- FF46=8'hE2 → source addresses start at 0xC200.
- Mid-transfer (idx=50), write FF46=8'hD0 → restart at START with idx=0 from 0xD000. Separately, assert rst at idx=80 → DMA_ACTIVE=0 next cycle and no further OAM_WR.
- LCD_EN=0, mode=DRAW → CPU VRAM and OAM reads and writes are all granted. CPU_RD at 0xFEB0 → 8'hFF.

Source files
------------

// File: rtl/ppu_pkg.sv
// Shared PPU types, memory-map constants and small decode helpers used by the
// VRAM/OAM arbiter and its OAM DMA engine.
package ppu_pkg;

  typedef enum logic [1:0] {
    H_BLANK = 2'd0,
    V_BLANK = 2'd1,
    SCAN    = 2'd2,
    DRAW    = 2'd3
  } PPU_STATES_t;

  // Where the data returned to a requester comes from on the cycle after its strobe.
  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_VRAM = 2'd1,
    SEL_OAM  = 2'd2,
    SEL_FF   = 2'd3
  } rd_sel_t;

  typedef enum logic [1:0] {
    DMA_IDLE  = 2'd0,
    DMA_START = 2'd1,
    DMA_READ  = 2'd2,
    DMA_WRITE = 2'd3
  } dma_state_t;

  localparam logic [15:0] OAM_BASE_ADDR  = 16'hFE00;
  localparam logic [15:0] OAM_END_ADDR   = 16'hFE9F;
  localparam logic [15:0] VRAM_BASE_ADDR = 16'h8000;
  localparam logic [15:0] DMA_REG_ADDR   = 16'hFF46;

  function automatic logic is_vram(input logic [15:0] addr);
    return addr[15:13] == VRAM_BASE_ADDR[15:13];
  endfunction

  function automatic logic is_oam(input logic [15:0] addr);
    return (addr >= OAM_BASE_ADDR) && (addr <= OAM_END_ADDR);
  endfunction

  // Sources at E0..FF would alias echo RAM; fold them back onto C0..DF.
  function automatic logic [7:0] dma_src_hi(input logic [7:0] value);
    return (value >= 8'hE0) ? (value - 8'h20) : value;
  endfunction

endpackage

// File: rtl/ppu_oam_dma.sv
// OAM DMA engine: on an FF46 write, copies DMA_LEN bytes from {src_hi, idx}
// into OAM[idx], alternating one read cycle and one write cycle per byte.
module ppu_oam_dma
  import ppu_pkg::*;
#(
  parameter int DMA_LEN = 160
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trig,
  input  logic [7:0]  trig_data,
  output logic        active,
  output logic        rd,
  output logic [15:0] addr,
  output logic        oam_wr,
  output logic [7:0]  oam_addr
);

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  dma_state_t state_reg;
  logic [7:0] idx_reg;
  logic [7:0] src_hi_reg;
  logic       active_reg;
  logic       rd_reg;
  logic       wr_reg;
  logic [15:0] addr_reg;

  // A trigger wins over every state, so a retrigger mid-transfer drops the byte in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= DMA_IDLE;
      idx_reg    <= 8'd0;
      src_hi_reg <= 8'd0;
      active_reg <= 1'b0;
      rd_reg     <= 1'b0;
      wr_reg     <= 1'b0;
      addr_reg   <= 16'd0;
    end else begin
      rd_reg   <= 1'b0;
      wr_reg   <= 1'b0;
      addr_reg <= 16'd0;
      if (trig) begin
        src_hi_reg <= dma_src_hi(trig_data);
        idx_reg    <= 8'd0;
        state_reg  <= DMA_START;
        active_reg <= 1'b1;
      end else begin
        case (state_reg)
          DMA_IDLE: begin
            active_reg <= 1'b0;
          end
          DMA_START: begin
            state_reg <= DMA_READ;
            rd_reg    <= 1'b1;
            addr_reg  <= {src_hi_reg, idx_reg};
          end
          DMA_READ: begin
            state_reg <= DMA_WRITE;
            wr_reg    <= 1'b1;
          end
          DMA_WRITE: begin
            if (idx_reg == LAST_IDX) begin
              state_reg  <= DMA_IDLE;
              active_reg <= 1'b0;
            end else begin
              idx_reg   <= idx_reg + 8'd1;
              state_reg <= DMA_READ;
              rd_reg    <= 1'b1;
              addr_reg  <= {src_hi_reg, idx_reg + 8'd1};
            end
          end
          default: begin
            state_reg  <= DMA_IDLE;
            active_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  assign active   = active_reg;
  assign rd       = rd_reg;
  assign addr     = addr_reg;
  assign oam_wr   = wr_reg;
  assign oam_addr = idx_reg;

endmodule

// File: rtl/ppu_mem_arbiter.sv
// VRAM/OAM arbiter between CPU, PPU fetch and OAM DMA with PPU-mode lockout.
// Define PPU_ARB_DMA_EN to build in the FF46-triggered OAM DMA engine.
module ppu_mem_arbiter
  import ppu_pkg::*;
#(
  parameter int DMA_LEN = 160
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        LCD_EN,
  input  logic [1:0]  PPU_MODE,
  input  logic [15:0] CPU_ADDR,
  input  logic        CPU_RD,
  input  logic        CPU_WR,
  input  logic [7:0]  CPU_DATA_out,
  output logic [7:0]  CPU_DATA_in,
  input  logic        PPU_RD,
  input  logic [15:0] PPU_ADDR,
  output logic [7:0]  PPU_DATA_in,
  output logic [12:0] VRAM_ADDR,
  output logic        VRAM_WR,
  output logic [7:0]  VRAM_WDATA,
  input  logic [7:0]  VRAM_RDATA,
  output logic [7:0]  OAM_ADDR,
  output logic        OAM_WR,
  output logic [7:0]  OAM_WDATA,
  input  logic [7:0]  OAM_RDATA,
  output logic [15:0] DMA_ADDR,
  output logic        DMA_RD,
  input  logic [7:0]  DMA_DATA_in,
  output logic        DMA_ACTIVE
);

  PPU_STATES_t mode;
  logic vram_locked;
  logic oam_mode_locked;
  logic cpu_access;
  logic cpu_vram_req, cpu_oam_req, ppu_vram_req, ppu_oam_req;
  logic cpu_vram_gnt, cpu_oam_gnt, ppu_vram_gnt, ppu_oam_gnt;
  logic cpu_dma_trig;

  logic        dma_active;
  logic        dma_rd;
  logic [15:0] dma_addr;
  logic        dma_oam_wr;
  logic [7:0]  dma_oam_addr;
  logic [7:0]  dma_oam_wdata;

  assign mode            = PPU_STATES_t'(PPU_MODE);
  assign vram_locked     = LCD_EN && (mode == DRAW);
  assign oam_mode_locked = LCD_EN && ((mode == SCAN) || (mode == DRAW));

  assign cpu_access   = !rst && (CPU_RD || CPU_WR);
  assign cpu_vram_req = cpu_access && is_vram(CPU_ADDR);
  assign cpu_oam_req  = cpu_access && is_oam(CPU_ADDR);
  assign ppu_vram_req = !rst && PPU_RD && is_vram(PPU_ADDR);
  assign ppu_oam_req  = !rst && PPU_RD && is_oam(PPU_ADDR);
  assign cpu_dma_trig = !rst && CPU_WR && (CPU_ADDR == DMA_REG_ADDR);

  // The PPU only takes a RAM when the CPU was not granted it this cycle; a lock
  // simply removes the CPU grant, which hands the port to the PPU.
  assign cpu_vram_gnt = cpu_vram_req && !vram_locked;
  assign ppu_vram_gnt = ppu_vram_req && !cpu_vram_gnt;
  assign cpu_oam_gnt  = cpu_oam_req && !oam_mode_locked && !dma_active;
  assign ppu_oam_gnt  = ppu_oam_req && !dma_oam_wr && !cpu_oam_gnt;

`ifdef PPU_ARB_DMA_EN
  ppu_oam_dma #(
    .DMA_LEN (DMA_LEN)
  ) u_oam_dma (
    .clk       (clk),
    .rst       (rst),
    .trig      (cpu_dma_trig),
    .trig_data (CPU_DATA_out),
    .active    (dma_active),
    .rd        (dma_rd),
    .addr      (dma_addr),
    .oam_wr    (dma_oam_wr),
    .oam_addr  (dma_oam_addr)
  );
  assign dma_oam_wdata = DMA_DATA_in;
`else
  logic unused_dma;
  assign unused_dma    = ^{DMA_DATA_in, cpu_dma_trig};
  assign dma_active    = 1'b0;
  assign dma_rd        = 1'b0;
  assign dma_addr      = 16'd0;
  assign dma_oam_wr    = 1'b0;
  assign dma_oam_addr  = 8'd0;
  assign dma_oam_wdata = 8'd0;
`endif

  assign DMA_ACTIVE = dma_active;
  assign DMA_RD     = dma_rd;
  assign DMA_ADDR   = dma_addr;

  always_comb begin
    VRAM_ADDR  = 13'd0;
    VRAM_WR    = 1'b0;
    VRAM_WDATA = 8'd0;
    if (cpu_vram_gnt) begin
      VRAM_ADDR  = CPU_ADDR[12:0];
      VRAM_WR    = CPU_WR;
      VRAM_WDATA = CPU_DATA_out;
    end else if (ppu_vram_gnt) begin
      VRAM_ADDR = PPU_ADDR[12:0];
    end
  end

  always_comb begin
    OAM_ADDR  = 8'd0;
    OAM_WR    = 1'b0;
    OAM_WDATA = 8'd0;
    if (dma_oam_wr) begin
      OAM_ADDR  = dma_oam_addr;
      OAM_WR    = 1'b1;
      OAM_WDATA = dma_oam_wdata;
    end else if (ppu_oam_gnt) begin
      OAM_ADDR = PPU_ADDR[7:0];
    end else if (cpu_oam_gnt) begin
      OAM_ADDR  = CPU_ADDR[7:0];
      OAM_WR    = CPU_WR;
      OAM_WDATA = CPU_DATA_out;
    end
  end

  // Port 0 is the CPU, port 1 the PPU; each keeps its own return select.
  logic [1:0]      rd_req;
  logic [1:0]      rd_vram_gnt;
  logic [1:0]      rd_oam_gnt;
  logic [1:0][7:0] rd_data;

  assign rd_req      = {PPU_RD, CPU_RD} & {2{!rst}};
  assign rd_vram_gnt = {ppu_vram_gnt, cpu_vram_gnt};
  assign rd_oam_gnt  = {ppu_oam_gnt, cpu_oam_gnt};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd_port
      rd_sel_t    sel_next;
      rd_sel_t    sel_reg;
      logic [7:0] data_next;

      always_comb begin
        sel_next = SEL_NONE;
        if (rd_req[gi]) begin
          if (rd_vram_gnt[gi]) begin
            sel_next = SEL_VRAM;
          end else if (rd_oam_gnt[gi]) begin
            sel_next = SEL_OAM;
          end else begin
            sel_next = SEL_FF;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          sel_reg <= SEL_NONE;
        end else begin
          sel_reg <= sel_next;
        end
      end

      always_comb begin
        data_next = 8'hFF;
        case (sel_reg)
          SEL_VRAM: data_next = VRAM_RDATA;
          SEL_OAM:  data_next = OAM_RDATA;
          default:  data_next = 8'hFF;
        endcase
      end

      assign rd_data[gi] = data_next;
    end
  endgenerate

  assign CPU_DATA_in = rd_data[0];
  assign PPU_DATA_in = rd_data[1];

endmodule

// File: tb/tb_ppu_mem_arbiter.sv
// Scoreboard bench for ppu_mem_arbiter: drivers queue expected reads, RAM writes
// and DMA source fetches; a negedge monitor pops and compares what the DUT does.
module tb_ppu_mem_arbiter;
  import ppu_pkg::*;

  logic        clk;
  logic        rst;
  logic        LCD_EN;
  logic [1:0]  PPU_MODE;
  logic [15:0] CPU_ADDR;
  logic        CPU_RD;
  logic        CPU_WR;
  logic [7:0]  CPU_DATA_out;
  logic [7:0]  CPU_DATA_in;
  logic        PPU_RD;
  logic [15:0] PPU_ADDR;
  logic [7:0]  PPU_DATA_in;
  logic [12:0] VRAM_ADDR;
  logic        VRAM_WR;
  logic [7:0]  VRAM_WDATA;
  logic [7:0]  VRAM_RDATA;
  logic [7:0]  OAM_ADDR;
  logic        OAM_WR;
  logic [7:0]  OAM_WDATA;
  logic [7:0]  OAM_RDATA;
  logic [15:0] DMA_ADDR;
  logic        DMA_RD;
  logic [7:0]  DMA_DATA_in;
  logic        DMA_ACTIVE;

  ppu_mem_arbiter #(.DMA_LEN(160)) dut (
    .clk          (clk),
    .rst          (rst),
    .LCD_EN       (LCD_EN),
    .PPU_MODE     (PPU_MODE),
    .CPU_ADDR     (CPU_ADDR),
    .CPU_RD       (CPU_RD),
    .CPU_WR       (CPU_WR),
    .CPU_DATA_out (CPU_DATA_out),
    .CPU_DATA_in  (CPU_DATA_in),
    .PPU_RD       (PPU_RD),
    .PPU_ADDR     (PPU_ADDR),
    .PPU_DATA_in  (PPU_DATA_in),
    .VRAM_ADDR    (VRAM_ADDR),
    .VRAM_WR      (VRAM_WR),
    .VRAM_WDATA   (VRAM_WDATA),
    .VRAM_RDATA   (VRAM_RDATA),
    .OAM_ADDR     (OAM_ADDR),
    .OAM_WR       (OAM_WR),
    .OAM_WDATA    (OAM_WDATA),
    .OAM_RDATA    (OAM_RDATA),
    .DMA_ADDR     (DMA_ADDR),
    .DMA_RD       (DMA_RD),
    .DMA_DATA_in  (DMA_DATA_in),
    .DMA_ACTIVE   (DMA_ACTIVE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM models and a patterned DMA source bus.
  logic [7:0] vram_mem [8192];
  logic [7:0] oam_mem [256];

  function automatic logic [7:0] src_byte(input logic [7:0] hi, input logic [7:0] lo);
    logic [7:0] t;
    t = lo * 8'd7;
    return t ^ hi;
  endfunction

  always @(posedge clk) begin
    if (VRAM_WR) vram_mem[VRAM_ADDR] <= VRAM_WDATA;
    VRAM_RDATA <= vram_mem[VRAM_ADDR];
    if (OAM_WR) oam_mem[OAM_ADDR] <= OAM_WDATA;
    OAM_RDATA <= oam_mem[OAM_ADDR];
    DMA_DATA_in <= src_byte(DMA_ADDR[15:8], DMA_ADDR[7:0]);
  end

  int checks = 0;
  int errors = 0;

  logic [7:0]  cpu_q[$];
  logic [7:0]  ppu_q[$];
  logic [20:0] vram_q[$];
  logic [15:0] oam_q[$];
  logic [15:0] dma_q[$];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endfunction

  function automatic void unexpected(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h with nothing expected at %0t", name, act, $time);
  endfunction

  // Monitor: read data is due one cycle after the strobe; RAM and DMA strobes are checked live.
  logic cpu_rd_d, ppu_rd_d;
  always @(posedge clk) begin
    cpu_rd_d <= CPU_RD && !rst;
    ppu_rd_d <= PPU_RD && !rst;
  end

  always @(negedge clk) begin
    if (cpu_rd_d) begin
      if (cpu_q.size() == 0) unexpected("cpu_rd_data", {24'd0, CPU_DATA_in});
      else check("cpu_rd_data", {24'd0, CPU_DATA_in}, {24'd0, cpu_q.pop_front()});
    end
    if (ppu_rd_d) begin
      if (ppu_q.size() == 0) unexpected("ppu_rd_data", {24'd0, PPU_DATA_in});
      else check("ppu_rd_data", {24'd0, PPU_DATA_in}, {24'd0, ppu_q.pop_front()});
    end
    if (VRAM_WR === 1'b1) begin
      if (vram_q.size() == 0) unexpected("vram_wr", {11'd0, VRAM_ADDR, VRAM_WDATA});
      else check("vram_wr addr_data", {11'd0, VRAM_ADDR, VRAM_WDATA}, {11'd0, vram_q.pop_front()});
    end
    if (OAM_WR === 1'b1) begin
      if (oam_q.size() == 0) unexpected("oam_wr", {16'd0, OAM_ADDR, OAM_WDATA});
      else check("oam_wr addr_data", {16'd0, OAM_ADDR, OAM_WDATA}, {16'd0, oam_q.pop_front()});
    end
    if (DMA_RD === 1'b1) begin
      if (dma_q.size() == 0) unexpected("dma_src_addr", {16'd0, DMA_ADDR});
      else check("dma_src_addr", {16'd0, DMA_ADDR}, {16'd0, dma_q.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_read(input logic [15:0] a, input logic [7:0] exp);
    CPU_ADDR = a;
    CPU_RD   = 1'b1;
    cpu_q.push_back(exp);
    tick();
    CPU_RD = 1'b0;
  endtask

  task automatic ppu_read(input logic [15:0] a, input logic [7:0] exp);
    PPU_ADDR = a;
    PPU_RD   = 1'b1;
    ppu_q.push_back(exp);
    tick();
    PPU_RD = 1'b0;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    CPU_ADDR     = a;
    CPU_DATA_out = d;
    CPU_WR       = 1'b1;
    tick();
    CPU_WR = 1'b0;
  endtask

  task automatic push_dma(input logic [7:0] hi, input int n_rd, input int n_wr);
    for (int k = 0; k < n_rd; k++) dma_q.push_back({hi, 8'(k)});
    for (int k = 0; k < n_wr; k++) oam_q.push_back({8'(k), src_byte(hi, 8'(k))});
  endtask

  task automatic wait_oam_drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      tick();
      if (oam_q.size() == 0) done = 1'b1;
    end
    check(name, {31'd0, done}, 32'd1);
  endtask

  task automatic wait_dma_idle(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      tick();
      if (DMA_ACTIVE === 1'b0) done = 1'b1;
    end
    check(name, {31'd0, done}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bit done;
    rst = 1'b1; LCD_EN = 1'b1; PPU_MODE = 2'd0;
    CPU_ADDR = 16'd0; CPU_RD = 1'b0; CPU_WR = 1'b0; CPU_DATA_out = 8'd0;
    PPU_RD = 1'b0; PPU_ADDR = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst cpu_data_in", {24'd0, CPU_DATA_in}, 32'hFF);
    check("rst ppu_data_in", {24'd0, PPU_DATA_in}, 32'hFF);
    check("rst vram_wr", {31'd0, VRAM_WR}, 32'd0);
    check("rst oam_wr", {31'd0, OAM_WR}, 32'd0);
    check("rst dma_active", {31'd0, DMA_ACTIVE}, 32'd0);
    check("rst dma_rd", {31'd0, DMA_RD}, 32'd0);
    check("rst vram_addr", {19'd0, VRAM_ADDR}, 32'd0);
    check("rst oam_addr", {24'd0, OAM_ADDR}, 32'd0);
    check("rst dma_addr", {16'd0, DMA_ADDR}, 32'd0);
    rst = 1'b0;

    // H_BLANK: CPU owns VRAM.
    vram_q.push_back({13'h0010, 8'h5A}); cpu_write(16'h8010, 8'h5A);
    vram_q.push_back({13'h0020, 8'hC7}); cpu_write(16'h8020, 8'hC7);
    vram_q.push_back({13'h0030, 8'hA5}); cpu_write(16'h8030, 8'hA5);

    // DRAW: CPU locked out, PPU gets VRAM.
    PPU_MODE = 2'd3;
    CPU_ADDR = 16'h8010; CPU_RD = 1'b1; PPU_ADDR = 16'h8020; PPU_RD = 1'b1;
    cpu_q.push_back(8'hFF); ppu_q.push_back(8'hC7);
    #3;
    check("draw vram_addr_from_ppu", {19'd0, VRAM_ADDR}, 32'h0020);
    tick();
    CPU_RD = 1'b0; PPU_RD = 1'b0;
    cpu_write(16'h8030, 8'h11);

    // H_BLANK: simultaneous VRAM read, CPU wins; dropped DRAW write left A5.
    PPU_MODE = 2'd0;
    CPU_ADDR = 16'h8010; CPU_RD = 1'b1; PPU_ADDR = 16'h8020; PPU_RD = 1'b1;
    cpu_q.push_back(8'h5A); ppu_q.push_back(8'hFF);
    tick();
    CPU_RD = 1'b0; PPU_RD = 1'b0;
    cpu_read(16'h8030, 8'hA5);
    ppu_read(16'h8010, 8'h5A);

    // OAM lockout by mode.
    PPU_MODE = 2'd2;
    cpu_write(16'hFE04, 8'h33);
    PPU_MODE = 2'd1;
    oam_q.push_back({8'h04, 8'h33}); cpu_write(16'hFE04, 8'h33);
    PPU_MODE = 2'd2;
    cpu_read(16'hFE04, 8'hFF);
    ppu_read(16'hFE04, 8'h33);
    PPU_MODE = 2'd0;
    cpu_read(16'hFE04, 8'h33);

    // LCD off: no mode lockout at all.
    LCD_EN = 1'b0; PPU_MODE = 2'd3;
    cpu_read(16'h8010, 8'h5A);
    vram_q.push_back({13'h0040, 8'h66}); cpu_write(16'h8040, 8'h66);
    cpu_read(16'h8040, 8'h66);
    oam_q.push_back({8'h08, 8'h77}); cpu_write(16'hFE08, 8'h77);
    cpu_read(16'hFE08, 8'h77);
    cpu_read(16'hFEB0, 8'hFF);
    cpu_write(16'hFEB0, 8'h99);
    cpu_read(16'hFEB0, 8'hFF);
    LCD_EN = 1'b1; PPU_MODE = 2'd0;

`ifdef PPU_ARB_DMA_EN
    // Full transfer from C100: 321 cycles, CPU locked out of OAM throughout.
    push_dma(8'hC1, 160, 160);
    cpu_write(16'hFF46, 8'hC1);
    check("dma_active_rise", {31'd0, DMA_ACTIVE}, 32'd1);
    CPU_ADDR = 16'hFE00; CPU_RD = 1'b1; cpu_q.push_back(8'hFF);
    n = 0; done = 1'b0;
    for (int i = 0; i < 500 && !done; i++) begin
      tick();
      n++;
      CPU_RD = (n == 100);
      if (n == 100) cpu_q.push_back(8'hFF);
      if (DMA_ACTIVE === 1'b0) done = 1'b1;
    end
    CPU_RD = 1'b0;
    check("dma_len_cycles", n, 32'd321);

    // E2 folds to C2; restart at idx 50 with D0.
    push_dma(8'hC2, 51, 50);
    cpu_write(16'hFF46, 8'hE2);
    wait_oam_drain("dma_reach_idx50");
    push_dma(8'hD0, 160, 160);
    cpu_write(16'hFF46, 8'hD0);
    wait_dma_idle("dma_restart_done");

    // Reset at idx 80 aborts; earlier bytes stay.
    push_dma(8'hC3, 81, 80);
    cpu_write(16'hFF46, 8'hC3);
    wait_oam_drain("dma_reach_idx80");
    rst = 1'b1;
    tick();
    check("dma_active_after_rst", {31'd0, DMA_ACTIVE}, 32'd0);
    check("dma_rd_after_rst", {31'd0, DMA_RD}, 32'd0);
    rst = 1'b0;
    repeat (200) tick();
    cpu_read(16'hFE4F, src_byte(8'hC3, 8'd79));
    cpu_read(16'hFE50, src_byte(8'hD0, 8'd80));
`else
    // Without the DMA engine FF46 writes do nothing.
    cpu_write(16'hFF46, 8'hC1);
    for (int i = 0; i < 4; i++) begin
      check("nodma dma_active", {31'd0, DMA_ACTIVE}, 32'd0);
      check("nodma dma_rd", {31'd0, DMA_RD}, 32'd0);
      check("nodma dma_addr", {16'd0, DMA_ADDR}, 32'd0);
      tick();
    end
    cpu_read(16'hFE08, 8'h77);
`endif

    repeat (3) tick();
    check("cpu_q_empty", cpu_q.size(), 32'd0);
    check("ppu_q_empty", ppu_q.size(), 32'd0);
    check("vram_q_empty", vram_q.size(), 32'd0);
    check("oam_q_empty", oam_q.size(), 32'd0);
    check("dma_q_empty", dma_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
